prf_free_list_banked: RTL

- Banked physical-register free list that supplies free PR tags to rename and accepts freed PR tags from retire.
- Storage is split into PRF_BANK_COUNT independent circular FIFOs. Bank b holds only PRs whose low LOG_PRF_BANK_COUNT bits equal b, so the tags it supplies always map to PRF bank b.
- Generalises PR count, bank count and architectural-register count. Adds per-bank/total occupancy reporting and a sticky overflow/underflow error flag.

---
 rtl/prf_free_list_banked_if.sv | 29 ++
 rtl/prf_free_list_banked.sv | 99 +++++++++
 2 files changed

// File: rtl/prf_free_list_banked_if.sv
// Rename/retire port bundle of the banked PR free list.
// The free list drives the slave side; rename and retire drive the master side.
interface prf_free_list_banked_if #(
    parameter int unsigned PR_COUNT       = 128,
    parameter int unsigned PRF_BANK_COUNT = 4
);
    localparam int unsigned LOG_PR_COUNT = $clog2(PR_COUNT);
    localparam int unsigned DEPTH        = PR_COUNT / PRF_BANK_COUNT;
    localparam int unsigned LOG_DEPTH    = $clog2(DEPTH);

    logic [PRF_BANK_COUNT-1:0]                    deq_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  deq_pr_by_bank;
    logic [PRF_BANK_COUNT-1:0]                    deq_req_by_bank;
    logic [PRF_BANK_COUNT-1:0]                    enq_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  enq_pr_by_bank;
    logic [PRF_BANK_COUNT-1:0][LOG_DEPTH:0]       free_cnt_by_bank;
    logic [LOG_PR_COUNT:0]                        free_cnt_total;
    logic                                         error;

    modport slave (
        output deq_valid_by_bank, deq_pr_by_bank, free_cnt_by_bank, free_cnt_total, error,
        input  deq_req_by_bank, enq_valid_by_bank, enq_pr_by_bank
    );

    modport master (
        input  deq_valid_by_bank, deq_pr_by_bank, free_cnt_by_bank, free_cnt_total, error,
        output deq_req_by_bank, enq_valid_by_bank, enq_pr_by_bank
    );
endinterface

// File: rtl/prf_free_list_banked.sv
// Banked physical-register free list: one circular FIFO per PRF bank, each holding
// only tags whose low bits select that bank, with occupancy counts and a sticky error.
module prf_free_list_banked #(
    parameter int unsigned PR_COUNT       = 128,
    parameter int unsigned PRF_BANK_COUNT = 4,
    parameter int unsigned AR_COUNT       = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    prf_free_list_banked_if.slave         bus
);
    localparam int unsigned LOG_PR_COUNT = $clog2(PR_COUNT);
    localparam int unsigned LOG_BANK     = $clog2(PRF_BANK_COUNT);
    localparam int unsigned DEPTH        = PR_COUNT / PRF_BANK_COUNT;
    localparam int unsigned LOG_DEPTH    = $clog2(DEPTH);
    localparam int unsigned INIT_CNT     = (PR_COUNT - AR_COUNT) / PRF_BANK_COUNT;

    localparam logic [LOG_DEPTH:0]    PTR_INIT   = (LOG_DEPTH+1)'(INIT_CNT);
    localparam logic [LOG_PR_COUNT:0] TOTAL_INIT = (LOG_PR_COUNT+1)'(PR_COUNT - AR_COUNT);

    logic [LOG_PR_COUNT-1:0] r_mem  [PRF_BANK_COUNT][DEPTH];
    logic [LOG_DEPTH:0]      r_head [PRF_BANK_COUNT];
    logic [LOG_DEPTH:0]      r_tail [PRF_BANK_COUNT];
    logic [LOG_DEPTH:0]      r_cnt  [PRF_BANK_COUNT];
    logic [LOG_PR_COUNT:0]   r_total;
    logic                    r_error;

    logic [PRF_BANK_COUNT-1:0] w_empty;
    logic [PRF_BANK_COUNT-1:0] w_full;
    logic [PRF_BANK_COUNT-1:0] w_pop;
    logic [PRF_BANK_COUNT-1:0] w_push;
    logic [LOG_DEPTH:0]        w_cnt_d [PRF_BANK_COUNT];
    logic [LOG_PR_COUNT:0]     w_total_d;
    logic                      w_err;

    always_comb begin
        w_err     = 1'b0;
        w_total_d = r_total;
        for (int b = 0; b < int'(PRF_BANK_COUNT); b++) begin
            w_empty[b] = (r_head[b] == r_tail[b]);
            w_full[b]  = (r_head[b][LOG_DEPTH-1:0] == r_tail[b][LOG_DEPTH-1:0]) &&
                         (r_head[b][LOG_DEPTH] != r_tail[b][LOG_DEPTH]);
            // Full/empty come from pre-edge pointers: no bypass on empty, no push on full.
            w_pop[b]   = bus.deq_req_by_bank[b] & ~w_empty[b];
            w_push[b]  = bus.enq_valid_by_bank[b] & ~w_full[b];
            w_cnt_d[b] = r_cnt[b];
            if (w_push[b] && !w_pop[b]) begin
                w_cnt_d[b] = r_cnt[b] + (LOG_DEPTH+1)'(1);
                w_total_d  = w_total_d + (LOG_PR_COUNT+1)'(1);
            end else if (w_pop[b] && !w_push[b]) begin
                w_cnt_d[b] = r_cnt[b] - (LOG_DEPTH+1)'(1);
                w_total_d  = w_total_d - (LOG_PR_COUNT+1)'(1);
            end
            if ((bus.deq_req_by_bank[b] && w_empty[b]) ||
                (bus.enq_valid_by_bank[b] && w_full[b]) ||
                (bus.enq_valid_by_bank[b] &&
                 (bus.enq_pr_by_bank[b][LOG_BANK-1:0] != LOG_BANK'(b)))) begin
                w_err = 1'b1;
            end
            bus.deq_valid_by_bank[b] = ~w_empty[b];
            bus.deq_pr_by_bank[b]    = r_mem[b][r_head[b][LOG_DEPTH-1:0]];
            bus.free_cnt_by_bank[b]  = r_cnt[b];
        end
    end

    assign bus.free_cnt_total = r_total;
    assign bus.error          = r_error;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < int'(PRF_BANK_COUNT); b++) begin
                r_head[b] <= '0;
                r_tail[b] <= PTR_INIT;
                r_cnt[b]  <= PTR_INIT;
                for (int k = 0; k < int'(DEPTH); k++) begin
                    r_mem[b][k] <= (k < int'(INIT_CNT)) ?
                        LOG_PR_COUNT'(int'(AR_COUNT) + b + k * int'(PRF_BANK_COUNT)) : '0;
                end
            end
            r_total <= TOTAL_INIT;
            r_error <= 1'b0;
        end else begin
            for (int b = 0; b < int'(PRF_BANK_COUNT); b++) begin
                if (w_push[b]) begin
                    r_mem[b][r_tail[b][LOG_DEPTH-1:0]] <= bus.enq_pr_by_bank[b];
                    r_tail[b] <= r_tail[b] + (LOG_DEPTH+1)'(1);
                end
                if (w_pop[b]) begin
                    r_head[b] <= r_head[b] + (LOG_DEPTH+1)'(1);
                end
                r_cnt[b] <= w_cnt_d[b];
            end
            r_total <= w_total_d;
            if (w_err) begin
                r_error <= 1'b1;
            end
        end
    end
endmodule
